// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM states
// and the encodings of the datapath select/ALU control fields.
package mcpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OTHER = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Control-output decode for the multi-cycle FSM: Moore on state, except the
// FETCH IR/PC loads which follow mem_ready. Build option: ILLEGAL_OP_TRAP_EN.
module multicycle_ctrl_outdec
    import mcpu_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_beq,
    output logic               pc_write_bne,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_enable,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               regdst,
    output logic               reg_write,
    output logic               jal,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               trap
);

    always_comb begin
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        pc_src       = PCSRC_ALU;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_enable   = 1'b1;
        mem_read     = 1'b1;
        mem_write    = 1'b1;
        mem_to_reg   = 1'b0;
        regdst       = 1'b0;
        reg_write    = 1'b0;
        jal          = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REGB;
        alu_op       = ALU_ADD;
        trap         = 1'b0;

        case (state)
            S_FETCH: begin
                mem_enable = 1'b0;
                mem_read   = 1'b0;
                alu_src_b  = SRCB_FOUR;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                iord       = 1'b1;
                mem_enable = 1'b0;
                mem_read   = 1'b0;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                iord       = 1'b1;
                mem_enable = 1'b0;
                mem_write  = 1'b0;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (opcode == OP_RTYPE) begin
                    alu_src_b = SRCB_REGB;
                    alu_op    = ALU_FUNCT;
                end else begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                end
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                regdst    = (opcode == OP_RTYPE);
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_REGB;
                alu_op       = ALU_SUB;
                pc_src       = PCSRC_ALUOUT;
                pc_write_beq = (opcode == OP_BEQ);
                pc_write_bne = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_src    = PCSRC_JUMP;
                jal       = (opcode == OP_JAL);
                reg_write = (opcode == OP_JAL);
            end
            S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                trap = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state decode and the
// retired-instruction counter. Build option: ILLEGAL_OP_TRAP_EN.
//
// state    | meaning
// IDLE     | one cycle after reset, all strobes inactive
// FETCH    | read instruction at PC, PC+4; waits on mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | base + sext(imm) address for LW/SW
// MEM_RD   | data read at ALUOut; waits on mem_ready
// MEM_WB   | MDR written to register file
// MEM_WR   | data write at ALUOut; waits on mem_ready
// EXEC     | R-type or ADDI ALU operation
// ALU_WB   | ALU result written to register file
// BRANCH   | compare regA/regB, conditional PC load
// JUMP     | PC <- jump target, JAL link write
// TRAP     | illegal opcode, held until reset
module multicycle_ctrl
    import mcpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_beq,
    output logic             pc_write_bne,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_enable,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             regdst,
    output logic             reg_write,
    output logic             jal,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t state_next;
    logic   retire;
    logic   unused_zero;

    // branch outcome is resolved in the datapath, not here
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:      state_next = S_MEM_ADDR;
                    OP_RTYPE, OP_ADDI: state_next = S_EXEC;
                    OP_BEQ, OP_BNE:    state_next = S_BRANCH;
                    OP_J, OP_JAL:      state_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_EXEC:     state_next = S_ALU_WB;
            S_ALU_WB:   state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_IDLE;
        endcase
    end

    // DECODE->FETCH for an unlisted opcode is a NOP and deliberately not counted
    assign retire = (state_next == S_FETCH) &&
                    (state inside {S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JUMP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .state        (state),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_beq (pc_write_beq),
        .pc_write_bne (pc_write_bne),
        .pc_src       (pc_src),
        .ir_write     (ir_write),
        .iord         (iord),
        .mem_enable   (mem_enable),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .regdst       (regdst),
        .reg_write    (reg_write),
        .jal          (jal),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .trap         (trap)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: latency/retire table, random instruction
// stream against an instruction-level reference model, reset and trap corner cases.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'h00;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_beq, pc_write_bne, ir_write, iord;
    logic             mem_enable, mem_read, mem_write, mem_to_reg, regdst;
    logic             reg_write, jal, alu_src_a, trap;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_beq(pc_write_beq), .pc_write_bne(pc_write_bne),
        .pc_src(pc_src), .ir_write(ir_write), .iord(iord), .mem_enable(mem_enable),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .regdst(regdst), .reg_write(reg_write), .jal(jal), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .retired(retired)
    );

    typedef struct packed {
        logic       pc_write, pc_write_beq, pc_write_bne;
        logic [1:0] pc_src;
        logic       ir_write, iord, mem_enable, mem_read, mem_write, mem_to_reg;
        logic       regdst, reg_write, jal, alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       trap;
    } ctl_t;

    typedef enum {P_IDLE, P_FETCH, P_DECODE, P_MADDR, P_MRD, P_MWB, P_MWR,
                  P_EXEC, P_AWB, P_BR, P_JMP, P_TRAP} phase_e;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        int         exp_cycles;
        int         exp_inc;
    } vec_t;

    int               n_chk = 0;
    int               n_pass = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    vec_t             tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    function automatic ctl_t actual_ctl();
        ctl_t c;
        c.pc_write = pc_write;     c.pc_write_beq = pc_write_beq; c.pc_write_bne = pc_write_bne;
        c.pc_src = pc_src;         c.ir_write = ir_write;         c.iord = iord;
        c.mem_enable = mem_enable; c.mem_read = mem_read;         c.mem_write = mem_write;
        c.mem_to_reg = mem_to_reg; c.regdst = regdst;             c.reg_write = reg_write;
        c.jal = jal;               c.alu_src_a = alu_src_a;       c.alu_src_b = alu_src_b;
        c.alu_op = alu_op;         c.trap = trap;
        return c;
    endfunction

    // Expected control word for one phase of an instruction, straight from the control table.
    function automatic ctl_t exp_ctl(input phase_e p, input logic [5:0] op, input logic mr);
        ctl_t c;
        c = '0;
        c.mem_enable = 1'b1; c.mem_read = 1'b1; c.mem_write = 1'b1;
        case (p)
            P_FETCH:  begin c.mem_enable = 0; c.mem_read = 0; c.alu_src_b = 2'b01;
                            c.ir_write = mr; c.pc_write = mr; end
            P_DECODE: c.alu_src_b = 2'b11;
            P_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            P_MRD:    begin c.iord = 1; c.mem_enable = 0; c.mem_read = 0; end
            P_MWB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
            P_MWR:    begin c.iord = 1; c.mem_enable = 0; c.mem_write = 0; end
            P_EXEC:   begin c.alu_src_a = 1;
                            if (op == 6'h00) begin c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
                            else begin c.alu_src_b = 2'b10; c.alu_op = 2'b00; end end
            P_AWB:    begin c.reg_write = 1; c.regdst = (op == 6'h00); end
            P_BR:     begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01;
                            c.pc_write_beq = (op == 6'h04); c.pc_write_bne = (op == 6'h05); end
            P_JMP:    begin c.pc_write = 1; c.pc_src = 2'b10;
                            c.jal = (op == 6'h03); c.reg_write = (op == 6'h03); end
            P_TRAP:   c.trap = 1;
            default:  ;
        endcase
        return c;
    endfunction

    task automatic cyc(input phase_e p, input logic [5:0] op, input logic mr, input string nm);
        @(negedge clk);
        mem_ready = mr;
        zero = 1'($urandom);
        opcode = (p == P_FETCH) ? 6'($urandom) : op;
        #1;
        check(nm, 64'(actual_ctl()), 64'(exp_ctl(p, op, mr)));
        check({nm, "_retired"}, 64'(retired), 64'(exp_ret));
    endtask

    // Reference model: one instruction as a sequence of phases with its own wait counts.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) cyc(P_FETCH, op, 1'b0, "fetch_wait");
        cyc(P_FETCH, op, 1'b1, "fetch");
        cyc(P_DECODE, op, 1'($urandom), "decode");
        case (op)
            6'h23: begin
                cyc(P_MADDR, op, 1'($urandom), "lw_addr");
                for (int i = 0; i < mw; i++) cyc(P_MRD, op, 1'b0, "lw_rd_wait");
                cyc(P_MRD, op, 1'b1, "lw_rd");
                cyc(P_MWB, op, 1'($urandom), "lw_wb");
                exp_ret++;
            end
            6'h2B: begin
                cyc(P_MADDR, op, 1'($urandom), "sw_addr");
                for (int i = 0; i < mw; i++) cyc(P_MWR, op, 1'b0, "sw_wr_wait");
                cyc(P_MWR, op, 1'b1, "sw_wr");
                exp_ret++;
            end
            6'h00, 6'h08: begin
                cyc(P_EXEC, op, 1'($urandom), "exec");
                cyc(P_AWB, op, 1'($urandom), "alu_wb");
                exp_ret++;
            end
            6'h04, 6'h05: begin
                cyc(P_BR, op, 1'($urandom), "branch");
                exp_ret++;
            end
            6'h02, 6'h03: begin
                cyc(P_JMP, op, 1'($urandom), "jump");
                exp_ret++;
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                for (int i = 0; i < 8; i++) cyc(P_TRAP, op, 1'($urandom), "trap_hold");
`endif
            end
        endcase
    endtask

    // Latency measured from DUT strobes: FETCH is the only phase with read low at address PC.
    task automatic run_table();
        int idx = 0, cnt = 0, pulses = 0, fl, ml;
        bit left = 0, fetch_now;
        fl = tbl[0].fw; ml = tbl[0].mw; opcode = tbl[0].op;
        while (idx < tbl.size()) begin
            @(negedge clk); #1;
            fetch_now = !mem_enable && !mem_read && !iord;
            if (fetch_now && left) begin
                check($sformatf("latency_%0d_op%02h", idx, tbl[idx].op), 64'(cnt), 64'(tbl[idx].exp_cycles));
                exp_ret = exp_ret + CNT_W'(tbl[idx].exp_inc);
                check($sformatf("retired_%0d_op%02h", idx, tbl[idx].op), 64'(retired), 64'(exp_ret));
                check($sformatf("ir_pulses_%0d_op%02h", idx, tbl[idx].op), 64'(pulses), 64'(1));
                idx++; cnt = 0; pulses = 0; left = 0;
                if (idx < tbl.size()) begin
                    opcode = tbl[idx].op; fl = tbl[idx].fw; ml = tbl[idx].mw;
                end
            end
            if (!fetch_now) left = 1;
            if (idx >= tbl.size()) mem_ready = 1'b0;
            else if (fetch_now) begin mem_ready = (fl == 0); if (fl > 0) fl--; end
            else if (iord) begin mem_ready = (ml == 0); if (ml > 0) ml--; end
            else mem_ready = 1'($urandom);
            #1;
            if (fetch_now && ir_write) pulses++;
            cnt++;
            if (cnt > 40) begin
                check($sformatf("latency_timeout_%0d", idx), 64'(cnt), 64'(tbl[idx].exp_cycles));
                summary();
            end
        end
    endtask

    initial begin
        logic [5:0] ops[10];
        int         n_ops;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h01, 6'h3F};
`ifdef ILLEGAL_OP_TRAP_EN
        n_ops = 8;
`else
        n_ops = 10;
`endif
        tbl.push_back('{6'h00, 0, 0, 4, 1});
        tbl.push_back('{6'h08, 0, 0, 4, 1});
        tbl.push_back('{6'h23, 0, 0, 5, 1});
        tbl.push_back('{6'h23, 2, 1, 8, 1});
        tbl.push_back('{6'h2B, 0, 0, 4, 1});
        tbl.push_back('{6'h2B, 1, 2, 7, 1});
        tbl.push_back('{6'h04, 0, 0, 3, 1});
        tbl.push_back('{6'h05, 1, 0, 4, 1});
        tbl.push_back('{6'h02, 0, 0, 3, 1});
        tbl.push_back('{6'h03, 0, 0, 3, 1});
`ifndef ILLEGAL_OP_TRAP_EN
        tbl.push_back('{6'h3F, 0, 0, 2, 0});
        tbl.push_back('{6'h01, 1, 0, 3, 0});
`endif

        // reset held, then released: one IDLE cycle, then FETCH
        repeat (2) begin
            @(negedge clk); #1;
            check("reset_ctl", 64'(actual_ctl()), 64'(exp_ctl(P_IDLE, 6'h00, 1'b0)));
            check("reset_retired", 64'(retired), 64'(0));
        end
        @(negedge clk); rst_n = 1'b1; #1;
        check("release_idle", 64'(actual_ctl()), 64'(exp_ctl(P_IDLE, 6'h00, 1'b0)));

        run_table();

        // named sequences
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 2, 1);
        run_instr(6'h2B, 0, 1);
        run_instr(6'h05, 0, 0);
        run_instr(6'h03, 0, 0);

        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(n_ops - 1, 0)], $urandom_range(2, 0), $urandom_range(3, 0));

        // asynchronous reset in the middle of a stalled MEM_RD
        cyc(P_FETCH, 6'h23, 1'b1, "rst_seq_fetch");
        cyc(P_DECODE, 6'h23, 1'b1, "rst_seq_decode");
        cyc(P_MADDR, 6'h23, 1'b1, "rst_seq_addr");
        cyc(P_MRD, 6'h23, 1'b0, "rst_seq_rd_wait");
        cyc(P_MRD, 6'h23, 1'b0, "rst_seq_rd_wait");
        rst_n = 1'b0;
        #1;
        check("midrd_reset_ctl", 64'(actual_ctl()), 64'(exp_ctl(P_IDLE, 6'h00, 1'b0)));
        check("midrd_reset_retired", 64'(retired), 64'(0));
        exp_ret = '0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("midrd_release_idle", 64'(actual_ctl()), 64'(exp_ctl(P_IDLE, 6'h00, 1'b0)));

        // 16 retirements wrap the 4-bit counter back to zero
        for (int n = 0; n < 16; n++) run_instr(6'h04, 0, 0);
        cyc(P_FETCH, 6'h02, 1'b1, "wrap_fetch");
        check("wrap_zero", 64'(retired), 64'(0));
        cyc(P_DECODE, 6'h02, 1'b1, "wrap_decode");
        cyc(P_JMP, 6'h02, 1'b1, "wrap_jump");
        exp_ret++;

        // unlisted opcode: NOP in the default build, sticky trap with ILLEGAL_OP_TRAP_EN
        run_instr(6'h3F, 1, 0);
`ifdef ILLEGAL_OP_TRAP_EN
        rst_n = 1'b0;
        #1;
        check("trap_cleared_by_reset", 64'(trap), 64'(0));
`else
        run_instr(6'h00, 0, 0);
`endif
        summary();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
